// File: rtl/seg7_display_decoder_pkg.sv
// seg7_display_decoder_pkg: segment bit indices, hex pattern table and decoder states
// shared by the seven-segment encoder and decoder so both ends agree on one table.
package seg7_display_decoder_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_display_decoder_lookup.sv
// seg7_pattern_lookup: combinational reverse lookup of a 7-segment pattern into
// its hex value, with legal-digit and blank flags.
module seg7_pattern_lookup
    import seg7_display_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       is_legal,
    output logic       is_blank
);

    always_comb begin
        value    = '0;
        is_legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX[i]) begin
                value    = 4'(i);
                is_legal = 1'b1;
            end
        end
    end

    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_display_decoder.sv
// seg7_display_decoder: synchronizes a 7-segment + dp bus, waits for a stable pattern
// and decodes it back to hex, flagging blank/illegal patterns and counting changes.
module seg7_display_decoder
    import seg7_display_decoder_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [6:0]       seg_in,
    input  logic             dp_in,
    input  logic             clr_err,
    output logic [3:0]       digit,
    output logic             dp_out,
    output logic             digit_valid,
    output logic             locked,
    output logic             blank,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] change_count
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [7:0]       sync_q [SYNC_STAGES];
    logic [7:0]       s;
    logic [7:0]       s_prev_q;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             changed;
    logic             fresh;
    state_e           state_q;
    logic [6:0]       last_pat_q;
    logic             none_q;
    logic [3:0]       digit_q;
    logic             dp_out_q;
    logic             digit_valid_q;
    logic             locked_q;
    logic             blank_q;
    logic             err_pulse_q;
    logic             err_sticky_q;
    logic [CNT_W-1:0] change_count_q;
    logic [3:0]       lk_value;
    logic             lk_legal;
    logic             lk_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {dp_in, seg_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign changed = (s != s_prev_q);

    always_comb begin
        cnt_d = (!enable || state_q == IDLE) ? 8'd0 :
                changed                      ? 8'd1 :
                (cnt_q == STABLE)            ? cnt_q : cnt_q + 8'd1;
    end

    // Evaluate a pattern only once per stable run: the cycle its count first hits the target.
    assign fresh = enable && (state_q != IDLE) && (cnt_d == STABLE) && (changed || cnt_q != STABLE);

    seg7_pattern_lookup u_lookup (
        .pattern  (s[6:0]),
        .value    (lk_value),
        .is_legal (lk_legal),
        .is_blank (lk_blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q       <= '0;
            cnt_q          <= '0;
            state_q        <= IDLE;
            last_pat_q     <= 7'h7F;
            none_q         <= 1'b1;
            digit_q        <= '0;
            dp_out_q       <= 1'b0;
            digit_valid_q  <= 1'b0;
            locked_q       <= 1'b0;
            blank_q        <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_sticky_q   <= 1'b0;
            change_count_q <= '0;
        end else begin
            s_prev_q      <= s;
            cnt_q         <= cnt_d;
            digit_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            if (clr_err) err_sticky_q <= 1'b0;
            if (!enable) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
            end else if (state_q == IDLE) begin
                state_q <= SETTLE;
            end else if (fresh && lk_legal) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                if (s[6:0] != last_pat_q || none_q) begin
                    digit_valid_q  <= 1'b1;
                    digit_q        <= lk_value;
                    dp_out_q       <= s[7];
                    blank_q        <= 1'b0;
                    change_count_q <= (&change_count_q) ? change_count_q : change_count_q + CNT_W'(1);
                    last_pat_q     <= s[6:0];
                    none_q         <= 1'b0;
                end
            end else if (fresh && lk_blank) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                blank_q    <= 1'b1;
                last_pat_q <= SEG_BLANK;
            end else if (fresh) begin
                state_q      <= SETTLE;
                locked_q     <= 1'b0;
                err_pulse_q  <= 1'b1;
                err_sticky_q <= 1'b1;
            end else if (changed) begin
                state_q  <= SETTLE;
                locked_q <= 1'b0;
            end
        end
    end

    assign digit        = digit_q;
    assign dp_out       = dp_out_q;
    assign digit_valid  = digit_valid_q;
    assign locked       = locked_q;
    assign blank        = blank_q;
    assign err_pulse    = err_pulse_q;
    assign err_sticky   = err_sticky_q;
    assign change_count = change_count_q;

endmodule

// File: tb/tb_seg7_display_decoder.sv
// tb_seg7_display_decoder: table-driven, directed and randomized checks of the
// seven-segment decoder against a run-length reference model.
module tb_seg7_display_decoder;

    localparam int STB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] seg_in;
    logic       dp_in;
    logic       clr_err;
    logic [3:0] digit;
    logic       dp_out;
    logic       digit_valid;
    logic       locked;
    logic       blank;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] change_count;

    seg7_display_decoder #(.SYNC_STAGES(2), .STABLE_CYCLES(STB), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .seg_in       (seg_in),
        .dp_in        (dp_in),
        .clr_err      (clr_err),
        .digit        (digit),
        .dp_out       (dp_out),
        .digit_valid  (digit_valid),
        .locked       (locked),
        .blank        (blank),
        .err_pulse    (err_pulse),
        .err_sticky   (err_sticky),
        .change_count (change_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int dv_n, ep_n, dv_last, ep_last, lock_drop;

    logic [6:0] hex_tab [16];

    typedef struct {
        logic [7:0] pat;
        logic       legal;
        logic [3:0] val;
        logic       blk;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_counts;
        dv_n = 0; ep_n = 0; dv_last = -1; ep_last = -1; lock_drop = 0;
    endtask

    task automatic run(input logic [7:0] p, input int n);
        seg_in = p[6:0];
        dp_in  = p[7];
        repeat (n) begin
            tick;
            if (digit_valid) begin dv_n++; dv_last = cyc; end
            if (err_pulse) begin ep_n++; ep_last = cyc; end
            if (!locked) lock_drop++;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; enable = 1'b1; seg_in = '0; dp_in = 1'b0; clr_err = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        zero_counts;
    endtask

    vec_t vt [23];
    int t0, t1, e_digit, e_blank;
    logic [7:0] q [$];
    logic [7:0] prev_s, sv, p;
    int run_len, m_digit, m_cnt, idx;
    logic [6:0] m_last;
    logic m_dp, m_blank, m_sticky, legal, blk, e_dv, e_ep, e_lock, clr_now;

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++) vt[i] = '{{1'b0, hex_tab[i]}, 1'b1, 4'(i), 1'b0};
        vt[16] = '{8'h86, 1'b1, 4'h1, 1'b0};
        vt[17] = '{8'h00, 1'b0, 4'h0, 1'b1};
        vt[18] = '{8'h12, 1'b0, 4'h0, 1'b0};
        vt[19] = '{8'h7E, 1'b0, 4'h0, 1'b0};
        vt[20] = '{8'h40, 1'b0, 4'h0, 1'b0};
        vt[21] = '{8'h80, 1'b0, 4'h0, 1'b1};
        vt[22] = '{8'h01, 1'b0, 4'h0, 1'b0};

        // reset state, checked while reset is held
        rst_n = 1'b0; enable = 1'b1; seg_in = 7'h5B; dp_in = 1'b1; clr_err = 1'b0;
        tick;
        chk("reset_outputs", 32'({digit, dp_out, digit_valid, locked, blank, err_pulse, err_sticky, change_count}), 0);

        // latency of first acceptance
        do_reset;
        run(8'h00, 8);
        zero_counts;
        t0 = cyc;
        run(8'h5B, 12);
        chk("lat_pulses", 32'(dv_n), 1);
        chk("lat_cycle", 32'(dv_last - t0), 6);
        chk("lat_digit", 32'(digit), 2);
        chk("lat_locked", 32'(locked), 1);
        chk("lat_count", 32'(change_count), 1);

        // repeated pattern does not pulse twice
        do_reset;
        run(8'h00, 8);
        zero_counts;
        run(8'h06, 10);
        chk("seq_digit1", 32'(digit), 1);
        run(8'h4F, 10);
        run(8'h4F, 10);
        chk("seq_pulses", 32'(dv_n), 2);
        chk("seq_digit3", 32'(digit), 3);
        chk("seq_count", 32'(change_count), 2);

        // short glitch back to the locked pattern
        do_reset;
        run(8'h66, 10);
        zero_counts;
        run(8'h7F, 2);
        run(8'h66, 10);
        chk("glitch_pulses", 32'(dv_n), 0);
        chk("glitch_lockdrop", 32'(lock_drop > 0), 1);
        chk("glitch_locked", 32'(locked), 1);
        chk("glitch_digit", 32'(digit), 4);

        // illegal pattern, clr_err, and set winning over clear
        do_reset;
        run(8'h00, 8);
        zero_counts;
        t0 = cyc;
        run(8'h12, 10);
        chk("ill_pulses", 32'(ep_n), 1);
        chk("ill_cycle", 32'(ep_last - t0), 6);
        chk("ill_sticky", 32'(err_sticky), 1);
        chk("ill_locked", 32'(locked), 0);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 0);
        seg_in = 7'h13;
        t1 = cyc;
        repeat (5) tick;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("setwin_cycle", 32'(cyc - t1), 6);
        chk("setwin_pulse", 32'(err_pulse), 1);
        chk("setwin_sticky", 32'(err_sticky), 1);

        // digit, blank, same digit again
        do_reset;
        run(8'h00, 8);
        zero_counts;
        run(8'h3F, 10);
        chk("blk_first", 32'(dv_n), 1);
        run(8'h00, 10);
        chk("blk_blank", 32'(blank), 1);
        chk("blk_nopulse", 32'(dv_n), 1);
        run(8'h3F, 10);
        chk("blk_pulses", 32'(dv_n), 2);
        chk("blk_count", 32'(change_count), 2);
        chk("blk_digit", 32'(digit), 0);
        chk("blk_cleared", 32'(blank), 0);

        // enable drop mid-settle, then reset mid-locked
        do_reset;
        run(8'h00, 8);
        run(8'h3F, 10);
        zero_counts;
        run(8'h5B, 3);
        enable = 1'b0;
        run(8'h5B, 6);
        chk("en_pulses", 32'(dv_n), 0);
        chk("en_locked", 32'(locked), 0);
        chk("en_digit", 32'(digit), 0);
        enable = 1'b1;
        run(8'h5B, 10);
        chk("reen_pulses", 32'(dv_n), 1);
        chk("reen_digit", 32'(digit), 2);
        zero_counts;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({digit, dp_out, digit_valid, locked, blank, err_pulse, err_sticky, change_count}), 0);
        tick;
        tick;
        rst_n = 1'b1;
        run(8'h5B, 12);
        chk("post_rst_pulses", 32'(dv_n), 1);
        chk("post_rst_digit", 32'(digit), 2);
        chk("post_rst_count", 32'(change_count), 1);

        // pattern table
        do_reset;
        run(8'h00, 8);
        e_digit = 0;
        e_blank = 1;
        for (int i = 0; i < 23; i++) begin
            run(vt[i].pat, 8);
            if (vt[i].legal) begin
                e_digit = int'(vt[i].val);
                e_blank = 0;
                chk($sformatf("tab_dp_%02h", vt[i].pat), 32'(dp_out), 32'(vt[i].pat[7]));
            end else if (vt[i].blk) begin
                e_blank = 1;
            end
            chk($sformatf("tab_locked_%02h", vt[i].pat), 32'(locked), 32'(vt[i].legal | vt[i].blk));
            chk($sformatf("tab_digit_%02h", vt[i].pat), 32'(digit), 32'(e_digit));
            chk($sformatf("tab_blank_%02h", vt[i].pat), 32'(blank), 32'(e_blank));
            chk($sformatf("tab_err_%02h", vt[i].pat), 32'(err_sticky), 32'(!vt[i].legal && !vt[i].blk));
            clr_err = 1'b1;
            tick;
            clr_err = 1'b0;
        end

        // randomized run against the run-length model, starting locked on blank
        do_reset;
        run(8'h00, 12);
        q = {8'h00, 8'h00};
        prev_s = 8'h00; run_len = 100; m_last = 7'h00;
        m_digit = 0; m_dp = 1'b0; m_cnt = 0; m_blank = 1'b1; m_sticky = 1'b0;
        p = 8'h00;
        for (int seg_i = 0; seg_i < 70; seg_i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: p[6:0] = hex_tab[$urandom_range(0, 15)];
                6:                p[6:0] = 7'h00;
                7, 8:             p[6:0] = 7'($urandom_range(0, 127));
                default:          ;
            endcase
            p[7] = ($urandom_range(0, 4) == 0);
            for (int h = $urandom_range(1, 8); h > 0; h--) begin
                seg_in  = p[6:0];
                dp_in   = p[7];
                clr_now = ($urandom_range(0, 15) == 0);
                clr_err = clr_now;
                q.push_back(p);
                tick;
                sv = q.pop_front();
                run_len = (sv == prev_s) ? (run_len < 1000 ? run_len + 1 : run_len) : 1;
                prev_s = sv;
                legal = 1'b0; idx = 0;
                for (int k = 0; k < 16; k++) if (hex_tab[k] == sv[6:0]) begin legal = 1'b1; idx = k; end
                blk = (sv[6:0] == 7'h00);
                e_dv = 1'b0; e_ep = 1'b0;
                if (run_len == STB) begin
                    if (legal && sv[6:0] != m_last) begin
                        e_dv = 1'b1; m_digit = idx; m_dp = sv[7];
                        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                        m_blank = 1'b0; m_last = sv[6:0];
                    end else if (blk) begin
                        m_blank = 1'b1; m_last = 7'h00;
                    end else if (!legal) begin
                        e_ep = 1'b1;
                    end
                end
                m_sticky = e_ep | (m_sticky & !clr_now);
                e_lock = (run_len >= STB) && (legal || blk);
                chk("rnd_valid", 32'(digit_valid), 32'(e_dv));
                chk("rnd_digit", 32'(digit), 32'(m_digit));
                chk("rnd_dp", 32'(dp_out), 32'(m_dp));
                chk("rnd_locked", 32'(locked), 32'(e_lock));
                chk("rnd_blank", 32'(blank), 32'(m_blank));
                chk("rnd_errp", 32'(err_pulse), 32'(e_ep));
                chk("rnd_sticky", 32'(err_sticky), 32'(m_sticky));
                chk("rnd_count", 32'(change_count), 32'(m_cnt));
            end
        end
        clr_err = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_display_decoder.md
Name: seg7_display_decoder

Overview:
- Receive-side companion to the seven-segment encoder path: samples a 7-segment pattern bus plus decimal point (e.g. looped back from uo_out).
- Waits until the pattern is stable, then decodes it back to a 4-bit hex value.
- Flags blank and illegal patterns and counts accepted digit changes.
- Used as an on-chip self-check and as a bench monitor for the display output.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on seg_in/dp_in before any logic (min 1).
- STABLE_CYCLES, 4, consecutive identical synced samples required before acceptance (min 1, max 255).
- CNT_W, 8, width of change_count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  decoder active; low forces IDLE
- seg_in  input  7  segments, active high, bit0=a … bit6=g
- dp_in  input  1  decimal point, active high
- clr_err  input  1  synchronous clear of err_sticky
- digit  output  4  last accepted hex value
- dp_out  output  1  decimal point captured with digit
- digit_valid  output  1  one-cycle pulse on acceptance of a new digit
- locked  output  1  current synced pattern is stable and accepted
- blank  output  1  accepted pattern is 0x00
- err_pulse  output  1  one-cycle pulse when an illegal pattern becomes stable
- err_sticky  output  1  latched illegal-pattern flag
- change_count  output  CNT_W  saturating count of digit_valid pulses

Behaviour:
- Reset values: all outputs 0. Internal `last_pat` is 0x7F with a "none" flag set, state IDLE, stability counter 0. Synchronizer flops also reset to 0.
- Legal patterns:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - 00 = blank
  - Anything else is illegal.
- Synchronizer: {dp_in, seg_in} passes through SYNC_STAGES flops; the result is `s`. `s_prev` is `s` delayed by one cycle.
- Stability counter `cnt`:
  - If `s != s_prev`, cnt = 1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - Comparisons include dp.
- States and transitions:
  - IDLE: entered on `!enable` from any state. locked=0, cnt held at 0. digit, dp_out and change_count hold. Leaving IDLE goes to SETTLE.
  - SETTLE → LOCKED when cnt reaches STABLE_CYCLES. Acceptance happens in the same cycle as this transition:
    - Legal hex, and (pattern != last_pat or "none" set): digit_valid=1 for one cycle, digit/dp_out updated, blank=0, change_count+1 (saturating at all-ones), last_pat updated, "none" cleared.
    - Legal hex equal to last_pat: no pulse, no count; locked=1.
    - Blank: blank=1, locked=1, no digit_valid; digit holds. last_pat becomes 00, so a following digit always pulses.
    - Illegal: err_pulse=1, err_sticky=1, locked=0; stays in SETTLE with cnt saturated until `s` changes. No repeated pulse.
  - LOCKED → SETTLE on `s != s_prev`: locked=0 the next cycle; digit holds.
- Latency: with a step on seg_in in cycle t and the input held constant, digit_valid is asserted in cycle t + SYNC_STAGES + STABLE_CYCLES. Defaults give t+6.
- Glitch rejection: a change lasting fewer than STABLE_CYCLES synced cycles produces no acceptance. If it returns to the locked pattern, no digit_valid is issued (same as last_pat).
- clr_err: clears err_sticky next cycle. If clr_err coincides with a new err_pulse, set wins.
- enable low mid-SETTLE aborts with no pulse. Re-enable restarts counting from cnt=1.
- rst_n asserted mid-operation: immediate return to reset values, independent of clk.

Decomposition:
- Shared include/package:
  - Segment-bit index constants (SEG_A..SEG_G).
  - The 16 hex pattern constants and SEG_BLANK, shared with the encoder so both ends use one table.
  - State encoding localparams: IDLE, SETTLE, LOCKED.
- One combinational sub-module, `seg7_pattern_lookup`: in 7-bit pattern; out value[3:0], is_legal, is_blank.
- Synchronizer chain, counter and FSM stay in the top module.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4):
- Reset, enable=1, seg_in=0x5B, dp=0 from cycle 10 → digit_valid only in cycle 16; digit=2, locked=1, change_count=1.
- Sequence 06, 4F, 4F-again (each held 10 cycles) → two pulses total, digits 1 then 3, change_count=2.
- Locked on 0x66, 2-cycle glitch to 0x7F, return to 0x66 → no digit_valid; locked drops then re-asserts; digit stays 4.
- seg_in=0x12 held 10 cycles → single err_pulse in cycle 6 after the step, err_sticky=1, locked=0. clr_err pulse → err_sticky=0 next cycle.
- 0x3F, then 0x00, then 0x3F → pulse, blank=1 with no pulse, then pulse again; change_count=2, digit=0.
- Drop enable mid-SETTLE, and separately assert rst_n low mid-LOCKED → no pulse in either case; after reset all outputs are 0 and the next stable pattern pulses.
